// File: rtl/panel_pkg.sv
// Shared types for the front-panel loader: sequencer states and switch-mode encoding.
package panel_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR_W,
        ADDR,
        WAIT,
        DATA,
        CLR_R,
        RUN
    } state_t;

    typedef logic [1:0] sw_mode_t;

    localparam sw_mode_t MODE_WRITE_DEF = 2'b01;
    localparam sw_mode_t MODE_RUN_DEF   = 2'b00;

    // States in which cpu_clk is driven by the tick generator.
    function automatic logic is_ticked(input state_t s);
        return (s == CLR_W) || (s == ADDR) || (s == DATA) || (s == CLR_R) || (s == RUN);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Phase/tick counter producing the computer clock level and a last-tick flag.
module tick_gen #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             enable,
    input  logic             reload,
    input  logic [CNT_W-1:0] ticks,
    output logic             clk_lvl,
    output logic             last_tick
);

    logic             phase;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!clr_n || reload) begin
            phase <= 1'b0;
            cnt   <= '0;
        end else if (enable) begin
            phase <= ~phase;
            if (phase) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign clk_lvl = phase;
    // High on the final high half-period, so the owning state exits with cpu_clk high.
    assign last_tick = phase && (cnt == ticks - 1'b1);

endmodule

// File: rtl/panel_loader.sv
// Front-panel sequencer: loads a program stream into the computer in write-memory mode, then runs it.
module panel_loader
    import panel_pkg::*;
#(
    parameter int       DATA_WIDTH = 16,
    parameter int       CLR_TICKS  = 2,
    parameter int       ADDR_TICKS = 4,
    parameter int       WORD_TICKS = 4,
    parameter int       RUN_TICKS  = 0,
    parameter sw_mode_t MODE_WRITE = MODE_WRITE_DEF,
    parameter sw_mode_t MODE_RUN   = MODE_RUN_DEF
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] base_addr,
    input  logic                  abort,
    input  logic                  stop,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  cpu_clk,
    output logic                  cpu_timing_clr,
    output logic                  cpu_pc_clr,
    output logic                  cpu_swa,
    output logic                  cpu_swb,
    output logic [DATA_WIDTH-1:0] cpu_data,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] word_count
);

    localparam logic [DATA_WIDTH-1:0] CLR_T  = DATA_WIDTH'(CLR_TICKS);
    localparam logic [DATA_WIDTH-1:0] ADDR_T = DATA_WIDTH'(ADDR_TICKS);
    localparam logic [DATA_WIDTH-1:0] WORD_T = DATA_WIDTH'(WORD_TICKS);
    localparam logic [DATA_WIDTH-1:0] RUN_T  = DATA_WIDTH'(RUN_TICKS);
    localparam logic                  RUN_LIMITED = (RUN_TICKS != 0);

    state_t                  state;
    state_t                  state_nxt;
    logic [DATA_WIDTH-1:0]   base_q;
    logic                    last_q;
    logic                    stop_pend;
    logic [DATA_WIDTH-1:0]   tick_sel;
    logic                    tg_enable;
    logic                    tg_reload;
    logic                    tg_clk;
    logic                    tg_last;
    logic                    run_exit;
    sw_mode_t                mode;

    always_comb begin
        tick_sel = CLR_T;
        case (state)
            ADDR:    tick_sel = ADDR_T;
            DATA:    tick_sel = WORD_T;
            RUN:     tick_sel = RUN_T;
            default: tick_sel = CLR_T;
        endcase
    end

    // A pending stop is held until the high half-period so cpu_clk falls on IDLE entry.
    assign run_exit = tg_clk && (stop || stop_pend || (RUN_LIMITED && tg_last));

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = CLR_W;
                CLR_W:   if (tg_last) state_nxt = ADDR;
                ADDR:    if (tg_last) state_nxt = WAIT;
                WAIT:    if (s_valid) state_nxt = DATA;
                DATA:    if (tg_last) state_nxt = last_q ? CLR_R : WAIT;
                CLR_R:   if (tg_last) state_nxt = RUN;
                RUN:     if (run_exit) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign tg_enable = is_ticked(state);
    assign tg_reload = (state_nxt != state) || !tg_enable;

    tick_gen #(
        .CNT_W (DATA_WIDTH)
    ) u_tick_gen (
        .clk       (clk),
        .clr_n     (clr_n),
        .enable    (tg_enable),
        .reload    (tg_reload),
        .ticks     (tick_sel),
        .clk_lvl   (tg_clk),
        .last_tick (tg_last)
    );

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state      <= IDLE;
            base_q     <= '0;
            last_q     <= 1'b0;
            stop_pend  <= 1'b0;
            cpu_data   <= '0;
            word_count <= '0;
            done       <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == RUN) && (state_nxt == IDLE) && !abort;
            if ((state == IDLE) && (state_nxt == CLR_W)) begin
                base_q     <= base_addr;
                word_count <= '0;
            end
            if ((state == CLR_W) && (state_nxt == ADDR)) begin
                cpu_data <= base_q;
            end
            if ((state == WAIT) && (state_nxt == DATA)) begin
                cpu_data <= s_data;
                last_q   <= s_last;
            end
            if ((state == DATA) && tg_last && !abort) begin
                word_count <= word_count + 1'b1;
            end
            if ((state == RUN) && stop) begin
                stop_pend <= 1'b1;
            end
            if (state_nxt != RUN) begin
                stop_pend <= 1'b0;
            end
        end
    end

    always_comb begin
        mode = MODE_RUN;
        if ((state == CLR_W) || (state == ADDR) || (state == WAIT) || (state == DATA)) begin
            mode = MODE_WRITE;
        end
    end

    assign cpu_clk        = tg_clk;
    assign cpu_timing_clr = (state == IDLE) || (state == CLR_W) || (state == CLR_R);
    assign cpu_pc_clr     = (state == CLR_W) || (state == CLR_R);
    assign cpu_swa        = mode[0];
    assign cpu_swb        = mode[1];
    assign s_ready        = (state == WAIT);
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_panel_loader.sv
// Scoreboard bench for panel_loader: load/run sequences, stalls, abort, ignored pulses and reset mid-load.
module tb_panel_loader;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          clr_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] base_addr = '0;
    logic          abort = 1'b0;
    logic          stop = 1'b0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic          cpu_clk;
    logic          cpu_timing_clr;
    logic          cpu_pc_clr;
    logic          cpu_swa;
    logic          cpu_swb;
    logic [DW-1:0] cpu_data;
    logic          busy;
    logic          done;
    logic [DW-1:0] word_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] exp_q[$];
    int            load_rises = 0;
    int            run_rises = 0;
    int            done_cnt = 0;
    logic          prev_clk = 1'b0;
    logic          prev_done = 1'b0;
    logic [1:0]    prev_mode = 2'b00;
    logic [DW-1:0] prev_data = '0;

    panel_loader #(
        .DATA_WIDTH (DW),
        .CLR_TICKS  (2),
        .ADDR_TICKS (4),
        .WORD_TICKS (4),
        .RUN_TICKS  (10)
    ) dut (
        .clk            (clk),
        .clr_n          (clr_n),
        .start          (start),
        .base_addr      (base_addr),
        .abort          (abort),
        .stop           (stop),
        .s_valid        (s_valid),
        .s_data         (s_data),
        .s_last         (s_last),
        .s_ready        (s_ready),
        .cpu_clk        (cpu_clk),
        .cpu_timing_clr (cpu_timing_clr),
        .cpu_pc_clr     (cpu_pc_clr),
        .cpu_swa        (cpu_swa),
        .cpu_swb        (cpu_swb),
        .cpu_data       (cpu_data),
        .busy           (busy),
        .done           (done),
        .word_count     (word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Accepted words become the next expected cpu_data values.
    always @(posedge clk) begin
        if (clr_n && s_valid && s_ready) exp_q.push_back(s_data);
    end

    always @(negedge clk) begin
        if (cpu_data !== prev_data) begin
            if (exp_q.size() == 0) chk("sb_unexpected", cpu_data, prev_data);
            else chk("sb_data", cpu_data, exp_q.pop_front());
        end
        if (cpu_clk && !prev_clk) begin
            if (busy && !cpu_timing_clr && {cpu_swb, cpu_swa} == 2'b00) run_rises++;
            else load_rises++;
        end
        if (done) begin
            done_cnt++;
            chk("done_width", prev_done, 0);
            chk("done_busy", busy, 0);
            chk("done_clk", cpu_clk, 0);
        end
        if (busy && {cpu_swb, cpu_swa} == 2'b00 && prev_mode == 2'b01)
            chk("mode_switch_pc_clr", cpu_pc_clr, 1);
        prev_data = cpu_data;
        prev_clk  = cpu_clk;
        prev_done = done;
        prev_mode = {cpu_swb, cpu_swa};
    end

    // sel: 0 = s_ready, 1 = RUN entered, 2 = done, 3 = ADDR/DATA write phase
    task automatic wait_for(input string tag, input int sel, input int limit);
        bit hit = 0;
        for (int i = 0; i < limit && !hit; i++) begin
            @(negedge clk);
            case (sel)
                0: hit = s_ready;
                1: hit = busy && !cpu_timing_clr && ({cpu_swb, cpu_swa} == 2'b00);
                2: hit = done;
                default: hit = busy && !cpu_timing_clr && ({cpu_swb, cpu_swa} == 2'b01) && !s_ready;
            endcase
        end
        if (!hit) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic do_start(input logic [DW-1:0] base);
        @(negedge clk);
        base_addr = base;
        start = 1'b1;
        exp_q.push_back(base);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [DW-1:0] d, input logic lst, input logic keep);
        wait_for("ready", 0, 200);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = lst;
        @(negedge clk);
        chk("accept_ready_low", s_ready, 0);
        if (!keep) begin
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_clk"}, cpu_clk, 0);
        chk({tag, "_tclr"}, cpu_timing_clr, 1);
        chk({tag, "_pcclr"}, cpu_pc_clr, 0);
        chk({tag, "_mode"}, {cpu_swb, cpu_swa}, 2'b00);
        chk({tag, "_ready"}, s_ready, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int lr0, rr0, dc0, hi;
        logic [DW-1:0] wc0;
        bit stall_bad;

        repeat (3) @(negedge clk);
        chk_idle("rst");
        chk("rst_data", cpu_data, 0);
        chk("rst_done", done, 0);
        chk("rst_wc", word_count, 0);
        clr_n = 1'b1;

        // Load 1: two words with s_valid held high, then RUN_TICKS expiry
        s_valid = 1'b1; s_data = 16'h1234; s_last = 1'b0;
        lr0 = load_rises;
        do_start(16'h0010);
        send_word(16'h1234, 1'b0, 1'b1);
        send_word(16'hABCD, 1'b1, 1'b0);
        wait_for("run1", 1, 200);
        chk("load1_rises", load_rises - lr0, 16);
        chk("load1_wc", word_count, 2);
        rr0 = run_rises;
        dc0 = done_cnt;
        repeat (3) @(negedge clk);
        base_addr = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_for("done1", 2, 100);
        chk("done1_busy", busy, 0);
        @(negedge clk);
        chk("done1_low", done, 0);
        chk("done1_once", done_cnt - dc0, 1);
        chk("run1_rises", run_rises - rr0, 10);
        chk("run1_wc", word_count, 2);

        // Load 2: stalled stream, stop in WAIT ignored, stop ends RUN early
        do_start(16'h0100);
        wait_for("wait2", 0, 200);
        stall_bad = 0;
        wc0 = word_count;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cpu_clk !== 1'b0 || s_ready !== 1'b1) stall_bad = 1;
            stop = (i == 10);
        end
        stop = 1'b0;
        chk("stall_clk_ready", stall_bad, 0);
        chk("stall_wc", word_count, wc0);
        send_word(16'h5555, 1'b0, 1'b0);
        send_word(16'h7777, 1'b1, 1'b0);
        wait_for("run2", 1, 300);
        chk("load2_wc", word_count, 2);
        rr0 = run_rises;
        hi = 0;
        for (int i = 0; i < 40 && hi < 3; i++) begin
            @(negedge clk);
            if (cpu_clk) hi++;
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_busy", busy, 0);
        chk("stop_done", done, 1);
        chk("stop_clk", cpu_clk, 0);
        @(negedge clk);
        chk("stop_rises", run_rises - rr0, 3);

        // Load 3: abort during ADDR k=3
        dc0 = done_cnt;
        do_start(16'h0200);
        wait_for("addr3", 3, 100);
        repeat (3) @(negedge clk);
        chk("addr_k3_clk", cpu_clk, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_idle("abort");
        chk("abort_done", done, 0);
        repeat (5) @(negedge clk);
        chk("abort_no_done", done_cnt - dc0, 0);

        // Load 4: clean reload after abort
        lr0 = load_rises;
        do_start(16'h0300);
        send_word(16'h0BEE, 1'b1, 1'b0);
        wait_for("run4", 1, 200);
        chk("load4_rises", load_rises - lr0, 12);
        chk("load4_wc", word_count, 1);
        rr0 = run_rises;
        wait_for("done4", 2, 100);
        @(negedge clk);
        chk("run4_rises", run_rises - rr0, 10);

        // Load 5: reset in the middle of the second DATA word
        do_start(16'h0400);
        send_word(16'h4321, 1'b0, 1'b0);
        send_word(16'h8765, 1'b0, 1'b0);
        chk("load5_wc", word_count, 1);
        repeat (2) @(negedge clk);
        clr_n = 1'b0;
        exp_q.push_back(16'h0000);
        @(negedge clk);
        clr_n = 1'b1;
        chk_idle("rst_mid");
        chk("rst_mid_wc", word_count, 0);
        chk("rst_mid_data", cpu_data, 0);
        repeat (4) @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/panel_loader.md
Name: panel_loader

Overview:
- Front-panel sequencer directly upstream of the microprogrammed computer top.
- Drives that top's clk, timing_clr, pc_clr, SWA, SWB and input_data.
- Takes a valid/ready stream of program words, steps the computer through write-memory mode (address word, then data words), then clears and releases it into run mode.
- Replaces manual switch/button operation in simulation and on board.

Parameters:
- DATA_WIDTH, 16: width of program words, input_data, base address, word counter.
- CLR_TICKS, 2: cpu_clk periods held in each clear phase.
- ADDR_TICKS, 4: cpu_clk periods the base address is presented.
- WORD_TICKS, 4: cpu_clk periods each data word is presented.
- RUN_TICKS, 0: cpu_clk periods in RUN before auto-stop; 0 = unlimited.
- MODE_WRITE, 2'b01: {SWB,SWA} for write-memory mode.
- MODE_RUN, 2'b00: {SWB,SWA} for run mode.

Ports:
- clk  in  1  system clock.
- clr_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins load; honoured only in IDLE.
- base_addr  in  DATA_WIDTH  load address, sampled on the start cycle.
- abort  in  1  one-cycle pulse; returns to IDLE from any state.
- stop  in  1  one-cycle pulse; ends RUN.
- s_valid  in  1  program word valid.
- s_data  in  DATA_WIDTH  program word.
- s_last  in  1  marks final program word.
- s_ready  out  1  loader accepts a word this cycle.
- cpu_clk  out  1  registered clock to computer clk.
- cpu_timing_clr  out  1  to timing_clr.
- cpu_pc_clr  out  1  to pc_clr.
- cpu_swa, cpu_swb  out  1 each  mode switches.
- cpu_data  out  DATA_WIDTH  to input_data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on return to IDLE from RUN (stop or RUN_TICKS expiry); not on abort.
- word_count  out  DATA_WIDTH  data words loaded since last start.

Behaviour:
- Interface: one clock, clk; reset clr_n, synchronous, active-low. All outputs registered or decoded from registered state.
- Reset (clr_n=0 at a clk edge) from any state, including mid-load or mid-run:
  - state=IDLE, cpu_clk=0, cpu_timing_clr=1, cpu_pc_clr=0, {swb,swa}=MODE_RUN.
  - cpu_data=0, s_ready=0, busy=0, done=0, word_count=0.
- Tick phasing in ticked states: phase counter k runs 0..2N-1; cpu_clk = k[0].
  - cpu_clk is low on the entry cycle, so cpu_data/mode are set up one clk before each cpu_clk rise.
  - A state of N ticks lasts exactly 2N clk cycles and exits with cpu_clk high; the next state's first cycle brings the falling edge.
- IDLE: cpu_clk=0, timing_clr=1. start -> CLR_W. Latch base_addr; word_count=0.
- CLR_W: mode=MODE_WRITE; timing_clr=1, pc_clr=1; CLR_TICKS ticks -> ADDR.
- ADDR: timing_clr=0, pc_clr=0; cpu_data=base_addr; ADDR_TICKS ticks -> WAIT.
- WAIT: cpu_clk held 0 (computer paused); s_ready=1.
  - s_valid&&s_ready: latch s_data and s_last -> DATA next cycle; s_ready=0 from that cycle.
  - Stays in WAIT indefinitely while s_valid=0.
- DATA: cpu_data=word; WORD_TICKS ticks. word_count increments on the exit cycle (wraps at 2^DATA_WIDTH). Exit -> CLR_R if latched last, else WAIT.
- CLR_R: mode=MODE_RUN; timing_clr=1, pc_clr=1; CLR_TICKS ticks -> RUN.
- RUN: timing_clr=0, pc_clr=0; cpu_clk free-runs (period 2 clk).
  - stop, or RUN_TICKS completed periods (if nonzero) -> IDLE, taken only on a cycle with cpu_clk high, so cpu_clk falls on the IDLE entry cycle.
  - done pulses on the IDLE entry cycle.
- abort: next cycle IDLE, regardless of phase; no done.
- Priority: clr_n > abort > stop > start. start outside IDLE ignored. stop outside RUN ignored.
- cpu_data holds its last value in WAIT and RUN. It changes only on state entry, never while cpu_clk is high.

Decomposition:
- Shared package panel_pkg:
  - state enum (IDLE, CLR_W, ADDR, WAIT, DATA, CLR_R, RUN).
  - MODE_* localparam defaults.
  - 2-bit switch-mode typedef.
- Sub-module tick_gen: phase counter plus tick counter.
  - Inputs: enable, reload, tick count.
  - Outputs: cpu_clk level, last-tick flag.
  - Reused by every ticked state.

Test Plan:
- Reset mid-DATA: clr_n low one cycle -> next cycle IDLE, cpu_clk=0, timing_clr=1, s_ready=0, word_count=0.
- start with base_addr=16'h0010, words 16'h1234, 16'hABCD(last), CLR_TICKS=2, ADDR_TICKS=4, WORD_TICKS=4, s_valid always high:
  - cpu_data sequence 0010, 1234, ABCD.
  - Exactly 2+4+4+4+2 cpu_clk rises before RUN.
  - word_count=2; {swb,swa} switches 01 -> 00 at CLR_R entry.
- Stalled stream: s_valid low 50 cycles in WAIT -> cpu_clk constant 0, s_ready=1 throughout, no word_count change. Accepted on first high cycle.
- RUN_TICKS=10 -> exactly 10 cpu_clk rises in RUN; done high one cycle; busy falls with IDLE entry.
- abort during ADDR (k=3) -> IDLE next cycle, done=0. Subsequent start reloads cleanly from CLR_W.
- start pulsed during RUN and stop pulsed during WAIT -> both ignored; state and counters unchanged.
